// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank.
// Contents:
//   DefWidth, DefNreg : default data width and register count
//   data_t            : default-width data word
//   sel_t             : default-width register select
// Files that instantiate the bank with other sizes use their own WIDTH/NREG parameters.
package reg_bank_pkg;

  localparam int DefWidth = 16;
  localparam int DefNreg  = 8;
  localparam int DefSelw  = $clog2(DefNreg);

  typedef logic [DefWidth-1:0] data_t;
  typedef logic [DefSelw-1:0]  sel_t;

endpackage

// File: rtl/reg_bank_if.sv
// Request/response bundle for reg_bank.
// Write port   : WR, WSEL, BIN
// Increment    : INC, ISEL
// Bus read     : LDBUS, BSEL -> BOUT, BOUT_VLD
// ALU read     : LDALU, ASEL -> ALU, ALU_VLD
// The master (the datapath controller) drives requests. The slave (reg_bank) returns read data.
interface reg_bank_if #(
  parameter int WIDTH = 16,
  parameter int SELW  = 3
);

  logic             WR;
  logic [SELW-1:0]  WSEL;
  logic [WIDTH-1:0] BIN;
  logic             INC;
  logic [SELW-1:0]  ISEL;
  logic             LDBUS;
  logic [SELW-1:0]  BSEL;
  logic             LDALU;
  logic [SELW-1:0]  ASEL;
  logic [WIDTH-1:0] BOUT;
  logic             BOUT_VLD;
  logic [WIDTH-1:0] ALU;
  logic             ALU_VLD;

  modport master (
    output WR, WSEL, BIN, INC, ISEL, LDBUS, BSEL, LDALU, ASEL,
    input  BOUT, BOUT_VLD, ALU, ALU_VLD
  );

  modport slave (
    input  WR, WSEL, BIN, INC, ISEL, LDBUS, BSEL, LDALU, ASEL,
    output BOUT, BOUT_VLD, ALU, ALU_VLD
  );

endinterface

// File: rtl/reg_cell.sv
// Single WIDTH-bit register with write and increment.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears q
//   wr    : load wdata (takes priority over inc)
//   inc   : q <= q + 1, wrapping modulo 2^WIDTH
//   wdata : write data
//   q     : current register value
module reg_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             inc,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (wr) begin
      q <= wdata;
    end else if (inc) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Bank of NREG registers with one write port, one increment port and two registered read ports
// (bus and ALU).
// Ports:
//   clk : clock, rising edge
//   RST : synchronous active-high reset (registers, read data and valid strobes)
//   bus : reg_bank_if slave modport (WR/WSEL/BIN, INC/ISEL, LDBUS/BSEL->BOUT/BOUT_VLD,
//         LDALU/ASEL->ALU/ALU_VLD)
// Option:
//   REG_BANK_BYPASS_EN: when defined, reads see same-cycle writes/increments (write-first).
//                       When undefined, reads return the pre-edge value.
// Selects >= NREG are ignored for WR/INC. For reads, they return 0 with the valid strobe set.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DefWidth,
  parameter int NREG  = DefNreg,
  parameter int SELW  = $clog2(NREG)
) (
  input  logic       clk,
  input  logic       RST,
  reg_bank_if.slave  bus
);

  logic [WIDTH-1:0] q      [NREG];
  logic [WIDTH-1:0] rd_val [NREG];
  logic [WIDTH-1:0] bout_d;
  logic [WIDTH-1:0] alu_d;

  for (genvar g = 0; g < NREG; g++) begin : g_cell
    logic wr_hit;
    logic inc_hit;

    // Out-of-range selects never match any cell, so they are dropped here.
    assign wr_hit  = bus.WR  && (bus.WSEL == SELW'(g));
    assign inc_hit = bus.INC && (bus.ISEL == SELW'(g));

    reg_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk   (clk),
      .rst   (RST),
      .wr    (wr_hit),
      .inc   (inc_hit),
      .wdata (bus.BIN),
      .q     (q[g])
    );

`ifdef REG_BANK_BYPASS_EN
    // Forward the value the cell will hold after this edge. WR wins over INC.
    assign rd_val[g] = wr_hit  ? bus.BIN :
                       inc_hit ? q[g] + WIDTH'(1) :
                                 q[g];
`else
    assign rd_val[g] = q[g];
`endif
  end

  // Read muxes. A select that matches no cell leaves the default 0.
  always_comb begin
    bout_d = '0;
    alu_d  = '0;
    for (int i = 0; i < NREG; i++) begin
      if (bus.BSEL == SELW'(i)) bout_d = rd_val[i];
      if (bus.ASEL == SELW'(i)) alu_d  = rd_val[i];
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      bus.BOUT     <= '0;
      bus.BOUT_VLD <= 1'b0;
      bus.ALU      <= '0;
      bus.ALU_VLD  <= 1'b0;
    end else begin
      bus.BOUT_VLD <= bus.LDBUS;
      bus.ALU_VLD  <= bus.LDALU;
      if (bus.LDBUS) bus.BOUT <= bout_d;
      if (bus.LDALU) bus.ALU  <= alu_d;
    end
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised successor to the single 16-bit bus/ALU register.
- Holds NREG registers of WIDTH bits, with one write port from the bus, one increment port, and two independent read ports: one drives the bus (BOUT), one drives the ALU mux (ALU).
- Read outputs are registered and carry valid strobes, so the datapath controller can issue bus and ALU reads in the same cycle.

Parameters:
- WIDTH, 16, data width of every register and datapath port.
- NREG, 8, number of registers; any value 2..256 is legal, not only powers of two.
- SELW, $clog2(NREG), width of every register-select port.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- WR  input  1  write strobe.
- WSEL  input  SELW  register written by WR.
- BIN  input  WIDTH  bus data to write.
- INC  input  1  increment strobe.
- ISEL  input  SELW  register incremented by INC.
- LDBUS  input  1  bus read request.
- BSEL  input  SELW  register read onto the bus.
- LDALU  input  1  ALU read request.
- ASEL  input  SELW  register read to the ALU.
- BOUT  output  WIDTH  registered bus read data.
- BOUT_VLD  output  1  BOUT updated this cycle.
- ALU  output  WIDTH  registered ALU read data.
- ALU_VLD  output  1  ALU updated this cycle.

Behaviour:
- Reset: when RST=1 at a clock edge, all registers, BOUT and ALU go to 0, and BOUT_VLD and ALU_VLD go to 0. RST overrides every other input in that cycle.
- Write: WR=1 loads BIN into reg[WSEL] at the edge.
- Increment: INC=1 sets reg[ISEL] to reg[ISEL]+1 modulo 2^WIDTH. All-ones wraps to 0 and no carry is reported.
- WR and INC to the same register in the same cycle: WR wins and the increment is dropped. To different registers, both take effect.
- Bus read latency: LDBUS=1 in cycle N gives BOUT = reg[BSEL] and BOUT_VLD=1 after edge N.
- Bus read hold: with LDBUS=0, BOUT holds its last value and BOUT_VLD=0.
- ALU read: ALU/ALU_VLD follow the same rules with LDALU/ASEL.
- LDBUS and LDALU are independent; there is no priority between them. Both may select the same register.
- Read of a register being written or incremented in the same cycle returns the pre-edge value (read-old). The optional feature below changes this.
- Out-of-range select (value >= NREG):
  - WR or INC: ignored, no state change.
  - Read: the output loads 0 with its valid strobe still asserted.
- There is no state machine. State is the register array plus two output registers and two valid flops.

Optional Feature:
- Macro REG_BANK_BYPASS_EN.
- Defined: write-first forwarding.
  - A read whose select equals WSEL while WR=1 returns BIN.
  - A read whose select equals ISEL while INC=1 and not overridden by WR returns reg+1.
  - Applies to both read ports.
- Undefined: read-old behaviour as stated above.

Decomposition:
- Shared package reg_bank_pkg:
  - Default WIDTH and NREG constants.
  - Typedef data_t (logic [WIDTH-1:0]).
  - Typedef sel_t.
- One natural sub-module, reg_cell:
  - Single WIDTH register with RST, WR, INC and WR-over-INC priority.
  - Instantiated NREG times via generate.
  - Read muxes and output registers stay in reg_bank.

Test Plan:
1. RST=1 one cycle after random traffic -> next cycle BOUT=0, ALU=0, both VLD=0; then LDBUS BSEL=3 -> BOUT=0x0000, BOUT_VLD=1.
2. WR WSEL=2 BIN=0xA5A5, next cycle LDBUS BSEL=2 and LDALU ASEL=2 -> after the edge BOUT=ALU=0xA5A5, both VLD=1.
3. Increment wrap: WR reg5=0xFFFF, then INC ISEL=5, then LDALU ASEL=5 -> ALU=0x0000.
4. Collision: WR WSEL=1 BIN=0x1234 with INC ISEL=1 in the same cycle, reg1 previously 0x0010 -> reg1=0x1234.
5. Same-cycle read/write: reg4=0x0007, WR WSEL=4 BIN=0x00FF with LDBUS BSEL=4 -> BOUT=0x0007 without the macro, 0x00FF with REG_BANK_BYPASS_EN.
6. Out-of-range select with NREG=6: WR WSEL=7 BIN=0xBEEF, then LDBUS BSEL=7 -> BOUT=0x0000 with BOUT_VLD=1, and reg0..reg5 unchanged.
